// File: rtl/fir_sequencer_pkg.sv
// Shared filter package: default geometry and the sequencer state encoding.
package fir_sequencer_pkg;

  localparam int unsigned FIR_NTAPS = 65;
  localparam int unsigned FIR_AW    = 7;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_CLEAR = 3'd0;
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd1;
  localparam logic [ST_W-1:0] ST_WRITE = 3'd2;
  localparam logic [ST_W-1:0] ST_ISSUE = 3'd3;
  localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/fir_addr_wrap.sv
// Modulo-NTAPS address helpers: (a-b) mod NTAPS and (a+1) mod NTAPS.
module fir_addr_wrap #(
  parameter int unsigned NTAPS = 65,
  parameter int unsigned AW    = 7
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] diff,
  output logic [AW-1:0] inc
);

  localparam int unsigned XW = AW + 1;

  logic [XW-1:0] d_raw;
  logic [XW-1:0] i_raw;

  // One extra bit holds a+NTAPS-b (< 2*NTAPS) without wrapping.
  always_comb begin
    d_raw = XW'(a) + XW'(NTAPS) - XW'(b);
    if (d_raw >= XW'(NTAPS)) d_raw = d_raw - XW'(NTAPS);
    i_raw = XW'(a) + XW'(1);
    if (i_raw >= XW'(NTAPS)) i_raw = '0;
    diff = AW'(d_raw);
    inc  = AW'(i_raw);
  end

endmodule

// File: rtl/fir_sequencer.sv
// FIR control sequencer: clears the delay line, writes samples into a circular
// buffer and walks NTAPS taps per sample for the external MAC datapath.
module fir_sequencer
  import fir_sequencer_pkg::*;
#(
  parameter int unsigned NTAPS = FIR_NTAPS,
  parameter int unsigned AW    = FIR_AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          endata,
  input  logic          ovr_clr,
  output logic          dl_we,
  output logic          zero_sel,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] coefaddress,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          dout_load,
  output logic          busy,
  output logic          overrun
);

  if ((64'd1 << AW) < 64'(NTAPS)) begin : g_bad_aw
    $error("fir_sequencer: AW too small for NTAPS");
  end

  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

  logic [ST_W-1:0] st, st_nxt;
  logic [AW-1:0]   k, k_nxt;
  logic [AW-1:0]   head, head_nxt;
  logic [AW-1:0]   newest, newest_nxt;
  logic [AW-1:0]   rd_nxt, inc_val;
  logic            live;
  logic            ovr_set;
  logic            issue_v;

  logic            dl_we_n, zero_sel_n, mac_clr_n, dout_load_n, busy_n, issue_n;
  logic [AW-1:0]   wr_addr_n, rd_addr_n, coef_n;

  // Distinguishes the reset-held period from the first CLEAR cycle.
  always_comb begin
    st_nxt  = st;
    k_nxt   = k;
    ovr_set = 1'b0;
    if (live) begin
      case (st)
        ST_CLEAR: begin
          ovr_set = endata;
          if (k == K_LAST) begin
            st_nxt = ST_IDLE;
            k_nxt  = '0;
          end else begin
            k_nxt = k + AW'(1);
          end
        end
        ST_IDLE:  if (endata) st_nxt = ST_WRITE;
        ST_WRITE: begin
          ovr_set = endata;
          st_nxt  = ST_ISSUE;
          k_nxt   = '0;
        end
        ST_ISSUE: begin
          ovr_set = endata;
          if (k == K_LAST) begin
            st_nxt = ST_DRAIN;
            k_nxt  = '0;
          end else begin
            k_nxt = k + AW'(1);
          end
        end
        ST_DRAIN: begin
          ovr_set = endata;
          st_nxt  = ST_DONE;
        end
        ST_DONE:  st_nxt = endata ? ST_WRITE : ST_IDLE;
        default: begin
          st_nxt = ST_CLEAR;
          k_nxt  = '0;
        end
      endcase
    end
  end

  assign newest_nxt = (live && st == ST_WRITE) ? head : newest;
  // In WRITE newest_nxt equals head, so the shared incrementer also advances head.
  assign head_nxt   = (live && st == ST_WRITE) ? inc_val : head;

  fir_addr_wrap #(
    .NTAPS (NTAPS),
    .AW    (AW)
  ) u_wrap (
    .a    (newest_nxt),
    .b    (k_nxt),
    .diff (rd_nxt),
    .inc  (inc_val)
  );

  // Outputs for the upcoming cycle, decoded from the next state.
  always_comb begin
    dl_we_n     = 1'b0;
    zero_sel_n  = 1'b0;
    wr_addr_n   = '0;
    rd_addr_n   = '0;
    coef_n      = '0;
    mac_clr_n   = 1'b0;
    dout_load_n = 1'b0;
    issue_n     = 1'b0;
    busy_n      = (st_nxt != ST_IDLE);
    case (st_nxt)
      ST_CLEAR: begin
        dl_we_n    = 1'b1;
        zero_sel_n = 1'b1;
        wr_addr_n  = k_nxt;
      end
      ST_WRITE: begin
        dl_we_n   = 1'b1;
        wr_addr_n = head_nxt;
      end
      ST_ISSUE: begin
        issue_n   = 1'b1;
        coef_n    = k_nxt;
        rd_addr_n = rd_nxt;
        mac_clr_n = (k_nxt == '0);
      end
      ST_DONE:  dout_load_n = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st          <= ST_CLEAR;
      k           <= '0;
      head        <= '0;
      newest      <= '0;
      live        <= 1'b0;
      issue_v     <= 1'b0;
      dl_we       <= 1'b0;
      zero_sel    <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      coefaddress <= '0;
      mac_clr     <= 1'b0;
      mac_en      <= 1'b0;
      dout_load   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      st          <= st_nxt;
      k           <= k_nxt;
      head        <= head_nxt;
      newest      <= newest_nxt;
      live        <= 1'b1;
      issue_v     <= issue_n;
      dl_we       <= dl_we_n;
      zero_sel    <= zero_sel_n;
      wr_addr     <= wr_addr_n;
      rd_addr     <= rd_addr_n;
      coefaddress <= coef_n;
      mac_clr     <= mac_clr_n;
      mac_en      <= issue_v;
      dout_load   <= dout_load_n;
      busy        <= busy_n;
      overrun     <= ovr_set | (overrun & ~ovr_clr);
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer against a transaction-timeline model.
module tb_fir_sequencer;

  localparam int N  = 65;
  localparam int AW = 7;

  localparam int M_PRE   = 0;
  localparam int M_CLEAR = 1;
  localparam int M_IDLE  = 2;
  localparam int M_TXN   = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          endata = 1'b0;
  logic          ovr_clr = 1'b0;
  logic          dl_we, zero_sel, mac_clr, mac_en, dout_load, busy, overrun;
  logic [AW-1:0] wr_addr, rd_addr, coefaddress;
  logic [27:0]   obs;

  int errors = 0;
  int checks = 0;

  // Model: mode, position within mode (txn: 0 write, 1..N taps, N+1 drain, N+2 done)
  int mode, cnt, head, newest;
  bit ov;

  fir_sequencer #(.NTAPS(N), .AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .endata      (endata),
    .ovr_clr     (ovr_clr),
    .dl_we       (dl_we),
    .zero_sel    (zero_sel),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .coefaddress (coefaddress),
    .mac_clr     (mac_clr),
    .mac_en      (mac_en),
    .dout_load   (dout_load),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  assign obs = {dl_we, zero_sel, wr_addr, rd_addr, coefaddress,
                mac_clr, mac_en, dout_load, busy, overrun};

  function automatic logic [27:0] exp_vec();
    logic dl, zs, mc, me, dlo, bz;
    logic [AW-1:0] wa, ra, ca;
    int kk;
    dl = 0; zs = 0; mc = 0; me = 0; dlo = 0; bz = 0;
    wa = '0; ra = '0; ca = '0;
    if (mode == M_CLEAR) begin
      dl = 1; zs = 1; bz = 1; wa = AW'(cnt);
    end else if (mode == M_TXN) begin
      bz = 1;
      if (cnt == 0) begin
        dl = 1; wa = AW'(newest);
      end
      if (cnt >= 1 && cnt <= N) begin
        kk = cnt - 1;
        ca = AW'(kk);
        ra = AW'((newest - kk + N) % N);
        mc = (kk == 0);
      end
      if (cnt >= 2 && cnt <= N + 1) me = 1;
      if (cnt == N + 2) dlo = 1;
    end
    return {dl, zs, wa, ra, ca, mc, me, dlo, bz, ov};
  endfunction

  function automatic void model_reset();
    mode = M_PRE; cnt = 0; head = 0; newest = 0; ov = 0;
  endfunction

  function automatic void start_txn();
    mode = M_TXN; cnt = 0; newest = head; head = (head + 1) % N;
  endfunction

  function automatic void model_advance(input bit en, input bit clr);
    bit drop;
    drop = en && (mode == M_CLEAR || (mode == M_TXN && cnt <= N + 1));
    ov = drop ? 1'b1 : (clr ? 1'b0 : ov);
    case (mode)
      M_PRE:   begin mode = M_CLEAR; cnt = 0; end
      M_CLEAR: if (cnt == N - 1) begin mode = M_IDLE; cnt = 0; end else cnt++;
      M_IDLE:  if (en) start_txn();
      default: begin
        if (cnt == N + 2) begin
          if (en) start_txn(); else mode = M_IDLE;
        end else cnt++;
      end
    endcase
  endfunction

  // Called ~1 time unit after a rising edge: compare, drive, advance one cycle.
  task automatic step(input bit en, input bit clr);
    logic [27:0] e;
    e = exp_vec();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL cycle@%0t: got %h expected %h (mode %0d cnt %0d)", $time, obs, e, mode, cnt);
    end
    endata = en; ovr_clr = clr;
    @(posedge clock); #1;
    model_advance(en, clr);
    endata = 0; ovr_clr = 0;
  endtask

  task automatic drive_samples(input int n);
    for (int i = 0; i < n; i++) begin
      if (mode == M_IDLE) step(1, 0);
      repeat (N + 2) step(0, 0);
      if (i < n - 1 && $urandom_range(0, 1) == 1) step(1, 0);
      else begin
        step(0, 0);
        repeat ($urandom_range(0, 2)) step(0, 0);
      end
    end
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 200 && mode != M_IDLE; i++) step(0, 0);
    checks++;
    if (mode != M_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_to_idle: busy=%b mode=%0d expected idle", busy, mode);
    end
  endtask

  task automatic test_reset();
    #3 reset = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (obs !== 28'h0) begin
      errors++; $display("FAIL reset_hold: got %h expected 0", obs);
    end
    reset = 1;
    repeat (N + 2) step(0, 0);
    checks++;
    if (busy !== 1'b0 || dl_we !== 1'b0) begin
      errors++; $display("FAIL clear_to_idle: busy=%b dl_we=%b expected 0 0", busy, dl_we);
    end
  endtask

  task automatic test_single();
    int fdl, fme, nme, fdo;
    fdl = -1; fme = -1; nme = 0; fdo = -1;
    for (int i = 0; i <= N + 4; i++) begin
      if (dl_we && fdl < 0) fdl = i;
      if (mac_en) begin nme++; if (fme < 0) fme = i; end
      if (dout_load) fdo = i;
      step(i == 0, 0);
    end
    checks++;
    if (fdl != 1) begin errors++; $display("FAIL lat_dl_we: got %0d expected 1", fdl); end
    checks++;
    if (fme != 3) begin errors++; $display("FAIL lat_mac_en: got %0d expected 3", fme); end
    checks++;
    if (nme != N) begin errors++; $display("FAIL mac_en_count: got %0d expected %0d", nme, N); end
    checks++;
    if (fdo != N + 3) begin errors++; $display("FAIL lat_dout_load: got %0d expected %0d", fdo, N + 3); end
  endtask

  task automatic test_head_wrap();
    drive_samples(N - 1 - head);
    step(1, 0);
    checks++;
    if (dl_we !== 1'b1 || wr_addr !== AW'(N - 1)) begin
      errors++; $display("FAIL wrap_write_top: dl_we=%b wr_addr=%0d expected 1 %0d", dl_we, wr_addr, N - 1);
    end
    repeat (N + 3) step(0, 0);
    step(1, 0);
    checks++;
    if (dl_we !== 1'b1 || wr_addr !== AW'(0)) begin
      errors++; $display("FAIL wrap_write_zero: dl_we=%b wr_addr=%0d expected 1 0", dl_we, wr_addr);
    end
    step(0, 0);
    checks++;
    if (rd_addr !== AW'(0) || mac_clr !== 1'b1) begin
      errors++; $display("FAIL wrap_rd0: rd_addr=%0d mac_clr=%b expected 0 1", rd_addr, mac_clr);
    end
    step(0, 0);
    checks++;
    if (rd_addr !== AW'(N - 1)) begin
      errors++; $display("FAIL wrap_rd1: rd_addr=%0d expected %0d", rd_addr, N - 1);
    end
    run_to_idle();
  endtask

  task automatic test_overrun();
    step(1, 0);
    repeat (11) step(0, 0);
    checks++;
    if (coefaddress !== AW'(10)) begin
      errors++; $display("FAIL ovr_pos: coefaddress=%0d expected 10", coefaddress);
    end
    step(1, 0);
    checks++;
    if (overrun !== 1'b1 || dl_we !== 1'b0) begin
      errors++; $display("FAIL ovr_set: overrun=%b dl_we=%b expected 1 0", overrun, dl_we);
    end
    repeat (5) step(0, 0);
    step(1, 1);
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_set_wins: overrun=%b expected 1", overrun);
    end
    step(0, 1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: overrun=%b expected 0", overrun);
    end
    run_to_idle();
  endtask

  task automatic test_back_to_back();
    step(1, 0);
    repeat (N + 2) step(0, 0);
    checks++;
    if (dout_load !== 1'b1) begin
      errors++; $display("FAIL b2b_done: dout_load=%b expected 1", dout_load);
    end
    step(1, 0);
    checks++;
    if (dl_we !== 1'b1 || busy !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_write: dl_we=%b busy=%b overrun=%b expected 1 1 0", dl_we, busy, overrun);
    end
    run_to_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    run_to_idle();
  endtask

  task automatic test_reset_mid();
    step(0, 1);
    step(1, 0);
    repeat (31) step(0, 0);
    checks++;
    if (coefaddress !== AW'(30)) begin
      errors++; $display("FAIL mid_pos: coefaddress=%0d expected 30", coefaddress);
    end
    #2 reset = 0;
    #1;
    model_reset();
    checks++;
    if (obs !== 28'h0) begin
      errors++; $display("FAIL async_reset: got %h expected 0", obs);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (obs !== 28'h0) begin
      errors++; $display("FAIL reset_no_load: got %h expected 0", obs);
    end
    reset = 1;
    repeat (N + 2) step(0, 0);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reclear_idle: busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_head_wrap();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 65, meaning the number of filter taps and delay-line depth.
REQ-002 SHALL have parameter AW, default 7, meaning the address width; it SHALL satisfy 2^AW >= NTAPS.
REQ-003 clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 endata  in  1  new-sample strobe, one cycle per sample.
REQ-006 ovr_clr  in  1  clears the overrun flag.
REQ-007 dl_we  out  1  delay-line write enable.
REQ-008 zero_sel  out  1  1 selects zero instead of datain as the delay-line write data.
REQ-009 wr_addr  out  AW  delay-line write address.
REQ-010 rd_addr  out  AW  delay-line read address.
REQ-011 coefaddress  out  AW  coefficient memory address.
REQ-012 mac_clr  out  1  clears the accumulator.
REQ-013 mac_en  out  1  accumulate the delay-line word times the coefficient word.
REQ-014 dout_load  out  1  registers the accumulator into dataout.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 overrun  out  1  sticky flag: a sample was dropped.

Function
REQ-017 SHALL implement states CLEAR, IDLE, WRITE, ISSUE, DRAIN and DONE.
REQ-018 CLEAR behaviour:
- entered on reset release;
- lasts NTAPS cycles;
- dl_we=1, zero_sel=1, wr_addr=0..NTAPS-1 ascending;
- then IDLE.
REQ-019 IDLE: endata=1 -> WRITE next cycle; otherwise stay.
REQ-020 WRITE:
- one cycle, dl_we=1, zero_sel=0, wr_addr=head;
- newest<=head;
- head advances modulo NTAPS (NTAPS-1 wraps to 0);
- then ISSUE.
REQ-021 ISSUE:
- NTAPS cycles, k=0..NTAPS-1;
- coefaddress=k;
- rd_addr=(newest-k) mod NTAPS;
- mac_clr=1 only when k=0;
- then DRAIN.
REQ-022 mac_en SHALL be the ISSUE-valid flag delayed by exactly one cycle; this matches the 1-cycle read latency of both memories.
REQ-023 DRAIN: one cycle, carrying the final mac_en; then DONE.
REQ-024 DONE:
- one cycle, dout_load=1;
- endata=1 in this cycle -> WRITE, sample accepted;
- otherwise -> IDLE.
REQ-025 Latency: endata accepted in IDLE at cycle 0 -> dl_we at cycle 1 -> first mac_en at cycle 3 -> dout_load at cycle NTAPS+3 (cycle 68 for 65 taps).
REQ-026 Outputs SHALL be 0 whenever their state is not active; dl_we and mac_clr SHALL never be high in the same cycle.
REQ-027 endata in CLEAR, WRITE, ISSUE or DRAIN: sample dropped, overrun set next cycle, no state change.
REQ-028 overrun SHALL hold until ovr_clr=1; if set and clear occur in the same cycle, set wins.
REQ-029 Address arithmetic SHALL use AW+1-bit intermediates with explicit modulo-NTAPS correction, never a power-of-two wrap.

Reset
REQ-030 Asserted reset (low) SHALL, at any time and in any state, immediately force:
- state=CLEAR, head=0, newest=0, k=0;
- all outputs 0, overrun=0;
- the mac_en delay register 0.
REQ-031 On release, CLEAR SHALL begin on the first rising edge; busy=1 from that edge.
REQ-032 Reset mid-ISSUE SHALL produce no dout_load for the aborted sample.

Structure
REQ-033 The state encoding and the default NTAPS/AW constants SHALL live in the shared filter package, also used by the filter datapath.
REQ-034 One sub-module, fir_addr_wrap, SHALL compute (a-b) mod NTAPS and (a+1) mod NTAPS, combinational.
REQ-035 No multiplier or memory SHALL reside in this block.

Verification
REQ-036 Reset release with endata=0 -> 65 cycles of dl_we=1, zero_sel=1, wr_addr 0..64 -> IDLE with busy=0.
REQ-037 Single endata in IDLE with head=0:
- cycle 1: dl_we with wr_addr=0;
- rd_addr sequence 0,64,63..1;
- 65 mac_en pulses starting cycle 3;
- dout_load at cycle 68.
REQ-038 Head wrap: after 64 samples (head=64), next sample -> wr_addr=64, then head=0; the following sample writes address 0 and reads 0,64,63..1.
REQ-039 endata at cycle 10 of ISSUE -> overrun=1 next cycle, no extra dl_we; ovr_clr and a second dropped endata in the same cycle -> overrun stays 1.
REQ-040 endata in the DONE cycle -> WRITE on the next cycle, no IDLE cycle, overrun stays 0.
REQ-041 Reset pulled low at k=30 -> outputs 0 asynchronously, no dout_load; after release, a 65-cycle CLEAR repeats.
